sc_button_cmd_fsm: RTL

Converts the two debounced, active-low push-button levels (clear and load) into single-cycle, active-low command strobes for the general-purpose register. It sits between the debounce stage and the register stage. It enforces one command per press, gives clear priority over load, and applies a configurable hold-off after release. It also keeps a wrapping count of issued commands for debug display.

---
 rtl/sc_button_cmd_fsm_pkg.sv | 23 ++
 rtl/sc_button_cmd_fsm_holdoff_counter.sv | 31 +++
 rtl/sc_button_cmd_fsm.sv | 119 +++++++++++
 3 files changed

// File: rtl/sc_button_cmd_fsm_pkg.sv
// Shared definitions for the push-button command FSM: state encoding and
// hold-off counter sizing.
package sc_button_cmd_fsm_pkg;

  // 3-bit binary state encoding, IDLE must stay at zero.
  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_CLEAR_PULSE  = 3'd1;
  localparam logic [2:0] ST_LOAD_PULSE   = 3'd2;
  localparam logic [2:0] ST_WAIT_RELEASE = 3'd3;
  localparam logic [2:0] ST_HOLDOFF      = 3'd4;

  // The hold-off counter only ever holds values up to cycles-1, so clog2
  // of the cycle count is enough; never narrower than one bit.
  function automatic int holdoff_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int HOLDOFF_CYCLES_DEFAULT = 4;
  localparam int HOLDOFF_W_DEFAULT      = holdoff_width(HOLDOFF_CYCLES_DEFAULT);

endpackage

// File: rtl/sc_button_cmd_fsm_holdoff_counter.sv
// Loadable down-counter with a zero flag; used to time the post-release
// hold-off window. Decrement stops at zero.
module sc_holdoff_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] value;

  // Load has priority over decrement; counter parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && (value != '0)) begin
      value <= value - ONE;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/sc_button_cmd_fsm.sv
// Turns debounced active-low clear/load button levels into single-cycle
// active-low command strobes: one strobe per press, clear beats load, and a
// hold-off window of continuous release is needed before the next press.
module sc_button_cmd_fsm
  import sc_button_cmd_fsm_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 4,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                   SC_BUTTONCMD_CLOCK_50,
  input  logic                   SC_BUTTONCMD_RESET_InLow,
  input  logic                   SC_BUTTONCMD_clear_InLow,
  input  logic                   SC_BUTTONCMD_load_InLow,
  output logic                   SC_BUTTONCMD_clear_OutLow,
  output logic                   SC_BUTTONCMD_load_OutLow,
  output logic                   SC_BUTTONCMD_busy_Out,
  output logic [COUNT_WIDTH-1:0] SC_BUTTONCMD_count_OutBUS
);

  localparam int HW       = holdoff_width(HOLDOFF_CYCLES);
  localparam int LOAD_INT = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;
  localparam logic [HW-1:0]          HOLD_LOAD = HW'(LOAD_INT);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  logic       clk;
  logic       rst_n;
  logic [2:0] state;
  logic [2:0] state_next;
  logic       clear_pressed;
  logic       load_pressed;
  logic       released;
  logic       hold_load;
  logic       hold_dec;
  logic       hold_zero;
  logic [COUNT_WIDTH-1:0] count;

  assign clk           = SC_BUTTONCMD_CLOCK_50;
  assign rst_n         = SC_BUTTONCMD_RESET_InLow;
  assign clear_pressed = ~SC_BUTTONCMD_clear_InLow;
  assign load_pressed  = ~SC_BUTTONCMD_load_InLow;
  assign released      = SC_BUTTONCMD_clear_InLow & SC_BUTTONCMD_load_InLow;

  sc_holdoff_counter #(
    .WIDTH (HW)
  ) u_holdoff (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (hold_load),
    .load_value (HOLD_LOAD),
    .dec        (hold_dec),
    .zero       (hold_zero)
  );

  // Next-state logic plus hold-off counter control.
  always_comb begin
    state_next = state;
    hold_load  = 1'b0;
    hold_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear_pressed) begin
          state_next = ST_CLEAR_PULSE;
        end else if (load_pressed) begin
          state_next = ST_LOAD_PULSE;
        end
      end
      ST_CLEAR_PULSE, ST_LOAD_PULSE: begin
        state_next = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (released) begin
          if (HOLDOFF_CYCLES > 0) begin
            state_next = ST_HOLDOFF;
            hold_load  = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_HOLDOFF: begin
        if (!released) begin
          // Bounce during hold-off: go back and wait for a clean release.
          state_next = ST_WAIT_RELEASE;
        end else if (hold_zero) begin
          state_next = ST_IDLE;
        end else begin
          hold_dec = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Issued-command counter, bumped on the edge that enters a pulse state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if ((state == ST_IDLE) && (clear_pressed || load_pressed)) begin
      count <= count + COUNT_ONE;
    end
  end

  assign SC_BUTTONCMD_clear_OutLow = (state != ST_CLEAR_PULSE);
  assign SC_BUTTONCMD_load_OutLow  = (state != ST_LOAD_PULSE);
  assign SC_BUTTONCMD_busy_Out     = (state != ST_IDLE);
  assign SC_BUTTONCMD_count_OutBUS = count;

endmodule
